// File: rtl/dmem_pkg.sv
// Shared types and constants for the 256-bit data-memory access controller.
package dmem_pkg;

  localparam int unsigned LANE_W     = 32;
  localparam int unsigned NUM_LANES  = 8;
  localparam int unsigned LANE_IDX_W = 3;
  localparam int unsigned MEM_A_W    = 256;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_access_ctrl_lane_merge.sv
// Combinational lane replace: the selected lane takes the new data, every other bit passes through.
module lane_merge #(
  parameter int unsigned LANE_W    = 32,
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [LANE_W*NUM_LANES-1:0] word_i,
  input  logic [IDX_W-1:0]            lane_i,
  input  logic [LANE_W-1:0]           data_i,
  output logic [LANE_W*NUM_LANES-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (lane_i == IDX_W'(k)) begin
        word_o[k*LANE_W +: LANE_W] = data_i;
      end
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Initiator for the 256-bit data memory: loads, full-word stores and read-modify-write lane stores,
// one request outstanding, valid/ready on both the request and response sides.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LANE_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_full,
  input  logic [LANE_IDX_W-1:0] req_lane,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  mem_WE,
  output logic [MEM_A_W-1:0]    mem_A,
  output logic [DATA_W-1:0]     mem_WD,
  input  logic [DATA_W-1:0]     mem_RD
);

  state_e                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [LANE_IDX_W-1:0]   lane_q;
  logic [LANE_W-1:0]       wdata_q;
  logic                    mem_we_q;
  logic [DATA_W-1:0]       mem_wd_q;
  logic                    resp_valid_q;
  logic [DATA_W-1:0]       resp_rdata_q;
  logic [DATA_W-1:0]       merged;

  lane_merge #(
    .LANE_W    (LANE_W),
    .NUM_LANES (DATA_W / LANE_W),
    .IDX_W     (LANE_IDX_W)
  ) u_merge (
    .word_i (mem_RD),
    .lane_i (lane_q),
    .data_i (wdata_q),
    .word_o (merged)
  );

  assign req_ready  = (state_q == IDLE) && rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_WE     = mem_we_q;
  assign mem_WD     = mem_wd_q;
  assign mem_A      = {{(MEM_A_W - ADDR_W){1'b0}}, addr_q};

  // Async reset clears mem_we_q at once, so an interrupted write never reaches the memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            lane_q  <= req_lane;
            wdata_q <= req_wdata[LANE_W-1:0];
            if (!req_we) begin
              state_q <= RD;
            end else if (req_full) begin
              mem_wd_q <= req_wdata;
              mem_we_q <= 1'b1;
              state_q  <= WR;
            end else begin
              state_q <= RMW_RD;
            end
          end
        end
        RD: begin
          resp_rdata_q <= mem_RD;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        WR: begin
          mem_we_q     <= 1'b0;
          resp_rdata_q <= mem_wd_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RMW_RD: begin
          mem_wd_q <= merged;
          mem_we_q <= 1'b1;
          state_q  <= RMW_WR;
        end
        RMW_WR: begin
          mem_we_q     <= 1'b0;
          resp_rdata_q <= mem_wd_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural 1024x256 memory plus an array-based reference model.
module tb_dmem_access_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_we, req_full;
  logic [2:0]   req_lane;
  logic [9:0]   req_addr;
  logic [255:0] req_wdata;
  logic         resp_valid, resp_ready;
  logic [255:0] resp_rdata;
  logic         mem_WE;
  logic [255:0] mem_A, mem_WD, mem_RD;

  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .ADDR_W (10),
    .DATA_W (256),
    .LANE_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_full   (req_full),
    .req_lane   (req_lane),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_WE     (mem_WE),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD)
  );

  // Behavioural memory with a bench-side preload port.
  logic [255:0] mem [0:1023];
  logic         bd_we;
  logic [9:0]   bd_a;
  logic [255:0] bd_d;

  always @(posedge clk) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
  end
  assign mem_RD = mem[mem_A[9:0]];

  logic [255:0] ref_mem [0:15];
  int errors = 0;
  int checks = 0;
  int we_cnt = 0;

  always @(negedge clk) if (mem_WE) we_cnt++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_lane(input logic [255:0] old, input int unsigned lane,
                                              input logic [31:0] d);
    logic [255:0] mask;
    mask = 256'hFFFF_FFFF << (32 * lane);
    return (old & ~mask) | (256'(d) << (32 * lane));
  endfunction

  task automatic xact(input string tag, input logic we, input logic full, input logic [2:0] lane,
                      input logic [9:0] addr, input logic [255:0] wd, input int hold,
                      output logic [255:0] rd);
    logic [255:0] exp;
    int lat, w0, exp_lat, exp_we, n;
    if (!we) begin
      exp = ref_mem[addr[3:0]]; exp_lat = 2; exp_we = 0;
    end else if (full) begin
      exp = wd; exp_lat = 2; exp_we = 1;
    end else begin
      exp = model_lane(ref_mem[addr[3:0]], lane, wd[31:0]); exp_lat = 3; exp_we = 1;
    end
    if (we) ref_mem[addr[3:0]] = exp;

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 256'(req_ready), 256'(1));
    req_we = we; req_full = full; req_lane = lane; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    w0 = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = {8{$urandom()}};
    req_lane  = 3'($urandom());
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check({tag, " latency"}, 256'(lat), 256'(exp_lat));
    rd = resp_rdata;
    check({tag, " rdata"}, rd, exp);
    for (int i = 0; i < hold; i++) begin
      check({tag, " hold req_ready"}, 256'(req_ready), 256'(0));
      check({tag, " hold resp_valid"}, 256'(resp_valid), 256'(1));
      check({tag, " hold rdata"}, resp_rdata, exp);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " resp_valid drop"}, 256'(resp_valid), 256'(0));
    check({tag, " we pulses"}, 256'(we_cnt - w0), 256'(exp_we));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rd, k5, wd;
    logic we, full;
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_full = 1'b0; req_lane = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;

    for (int i = 0; i < 16; i++) begin
      bd_we = 1'b1;
      bd_a  = 10'(i);
      if (i == 0) bd_d = {8{32'hBEEF_CAFE}};
      else if (i == 9) bd_d = '1;
      else if (i == 10) bd_d = '0;
      else bd_d = {8{$urandom()}};
      ref_mem[i] = bd_d;
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;

    check("rst req_ready low", 256'(req_ready), 256'(0));
    check("rst mem_WE", 256'(mem_WE), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("init req_ready", 256'(req_ready), 256'(1));
    check("init resp_valid", 256'(resp_valid), 256'(0));
    check("init resp_rdata", resp_rdata, '0);
    check("init mem_A", mem_A, '0);
    check("init mem_WD", mem_WD, '0);

    // Abort a full store while mem_WE is high.
    @(negedge clk);
    req_we = 1'b1; req_full = 1'b1; req_addr = 10'd7; req_wdata = {8{32'h5555_AAAA}};
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort mem_WE in WR", 256'(mem_WE), 256'(1));
    check("abort mem_A in WR", mem_A, 256'd7);
    #1;
    rst = 1'b0;
    #1;
    check("abort mem_WE dropped", 256'(mem_WE), 256'(0));
    check("abort mem_WD", mem_WD, '0);
    check("abort req_ready", 256'(req_ready), 256'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort word unchanged", mem[7], ref_mem[7]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-abort req_ready", 256'(req_ready), 256'(1));
    check("post-abort resp_valid", 256'(resp_valid), 256'(0));
    check("post-abort resp_rdata", resp_rdata, '0);
    check("post-abort mem_A", mem_A, '0);
    check("post-abort mem_WE", 256'(mem_WE), 256'(0));

    xact("load0", 1'b0, 1'b1, 3'd5, 10'd0, '0, 0, rd);
    check("load0 const", rd, {8{32'hBEEF_CAFE}});

    k5 = {4{64'h1234_5678_9ABC_DEF0}};
    xact("store5", 1'b1, 1'b1, 3'd0, 10'd5, k5, 0, rd);
    check("store5 mem", mem[5], k5);
    xact("load5", 1'b0, 1'b0, 3'd2, 10'd5, '0, 0, rd);
    check("load5 const", rd, k5);

    xact("lane3", 1'b1, 1'b0, 3'd3, 10'd9, {{7{$urandom()}}, 32'hDEAD_BEEF}, 0, rd);
    check("lane3 const", rd, {{4{32'hFFFF_FFFF}}, 32'hDEAD_BEEF, {3{32'hFFFF_FFFF}}});
    check("lane3 mem", mem[9], {{4{32'hFFFF_FFFF}}, 32'hDEAD_BEEF, {3{32'hFFFF_FFFF}}});
    xact("lane0", 1'b1, 1'b0, 3'd0, 10'd10, {{7{$urandom()}}, 32'h0000_0001}, 0, rd);
    check("lane0 const", rd, 256'd1);
    xact("lane7", 1'b1, 1'b0, 3'd7, 10'd10, {{7{$urandom()}}, 32'hA5A5_A5A5}, 0, rd);
    check("lane7 const", rd, {32'hA5A5_A5A5, 192'd0, 32'h0000_0001});

    xact("hold", 1'b0, 1'b0, 3'd0, 10'd0, '0, 10, rd);

    for (int t = 0; t < 100; t++) begin
      we   = 1'($urandom());
      full = 1'($urandom());
      for (int l = 0; l < 8; l++) wd[l*32 +: 32] = $urandom();
      xact("rand", we, full, 3'($urandom()), 10'($urandom_range(0, 15)), wd, 0, rd);
    end

    for (int i = 0; i < 16; i++) check("final mem", mem[i], ref_mem[i]);
    check("mem_A upper zero", 256'(mem_A[255:10]), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
